// File: rtl/channel_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// channel_accumulator_pkg
//
// Shared constants for the SpMV per-channel multiply-accumulate stage and its
// upstream FIFOs.
//
//   mult_bits            product width used by every channel
//   DEFAULT_DATA_W       matrix / vector value width
//   DEFAULT_ROW_W        row index and result address width
//   DEFAULT_ACC_W        accumulator and result write-data width
//   DEFAULT_FLUSH_CYCLES idle cycles before a pending row sum is written out
//   FIFO_DEPTH           depth of the upstream first-word-fall-through FIFOs
//
// cnt_width(n) returns the number of bits needed to hold the value n.
// -----------------------------------------------------------------------------
package channel_accumulator_pkg;

    localparam int mult_bits            = 16;
    localparam int DEFAULT_DATA_W       = 8;
    localparam int DEFAULT_ROW_W        = 8;
    localparam int DEFAULT_ACC_W        = 16;
    localparam int DEFAULT_FLUSH_CYCLES = 4;
    localparam int FIFO_DEPTH           = 16;

    // Bits required to represent max_val (at least 1).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo
//
// Synchronous first-word-fall-through FIFO feeding the channel accumulator.
// The head word is visible on dout whenever empty is low; rd_en pops it on
// the next rising edge.
//
// Boundary behaviour:
//   - a write while full is dropped, a read while empty is dropped;
//   - a read together with a write while full is accepted on both sides, so
//     the count stays at DEPTH;
//   - a read together with a write while empty passes din straight through to
//     dout and consumes it, so the count stays at 0.
//
// Ports:
//   clk, rst  rising-edge clock, synchronous active-high reset
//   wr_en     push din
//   din       write data (WIDTH)
//   full      count == DEPTH
//   rd_en     pop head word
//   dout      head word (din while empty, for the pass-through case)
//   empty     count == 0
//   count     number of stored words
// -----------------------------------------------------------------------------
module fifo
    import channel_accumulator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       din,
    output logic                   full,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);

    // A pop frees the slot a simultaneous push needs, and a push supplies the
    // word a simultaneous pop on an empty FIFO takes.
    assign do_wr = wr_en && (!full || rd_en);
    assign do_rd = rd_en && (!empty || wr_en);

    assign dout = empty ? din : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/channel_accumulator.sv
// -----------------------------------------------------------------------------
// channel_accumulator
//
// Per-channel multiply-accumulate stage of the SpMV engine. Pops one matrix
// nonzero, the matching vector element and the nonzero's row index from three
// first-word-fall-through FIFOs, multiplies them, sums consecutive products
// sharing a row index and writes each completed row sum to the result RAM.
//
// Configuration macro:
//   CHAN_ACC_SATURATE_EN  defined: the row sum saturates at 2^ACC_W-1.
//                         undefined (default): the row sum wraps mod 2^ACC_W.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   matrix_val         head of matrix-value FIFO      (DATA_W)
//   matrix_val_empty   matrix-value FIFO empty
//   matrix_val_rd_en   pop matrix-value FIFO
//   vec_val            head of vector-value FIFO      (DATA_W)
//   vec_val_empty      vector-value FIFO empty
//   vec_val_rd_en      pop vector-value FIFO
//   row_id_out         head of row-index FIFO         (ROW_W)
//   row_id_empty       row-index FIFO empty
//   row_id_rd_en       pop row-index FIFO
//   mult_out           registered product             (MULT_BITS)
//   mult_rd_en         mult_out valid strobe
//   wr_data            completed row sum              (ACC_W)
//   wr_addr            result address = row index     (ROW_W)
//   wr_en              one-cycle result write strobe per row
// -----------------------------------------------------------------------------
module channel_accumulator
    import channel_accumulator_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int ROW_W        = DEFAULT_ROW_W,
    parameter int MULT_BITS    = mult_bits,
    parameter int ACC_W        = DEFAULT_ACC_W,
    parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    matrix_val,
    input  logic                 matrix_val_empty,
    output logic                 matrix_val_rd_en,
    input  logic [DATA_W-1:0]    vec_val,
    input  logic                 vec_val_empty,
    output logic                 vec_val_rd_en,
    input  logic [ROW_W-1:0]     row_id_out,
    input  logic                 row_id_empty,
    output logic                 row_id_rd_en,
    output logic [MULT_BITS-1:0] mult_out,
    output logic                 mult_rd_en,
    output logic [ACC_W-1:0]     wr_data,
    output logic [ROW_W-1:0]     wr_addr,
    output logic                 wr_en
);

    localparam int               CNT_W      = cnt_width(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] FLUSH_MAX  = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    // Upstream handshake: a FIFO head is "valid" while its empty flag is low,
    // and rd_en is the "ready" that consumes it on the next rising edge. The
    // three FIFOs are only ever popped together, and only when all three heads
    // are valid, so a transfer is always a complete (value, vector, row) set.
    logic go;

    assign go               = !rst && !matrix_val_empty && !vec_val_empty && !row_id_empty;
    assign matrix_val_rd_en = go;
    assign vec_val_rd_en    = go;
    assign row_id_rd_en     = go;

    // ---------------------------------------------------------------- stage 1
    logic [ROW_W-1:0] p_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            mult_out   <= '0;
            mult_rd_en <= 1'b0;
            p_row      <= '0;
        end else begin
            mult_rd_en <= go;
            if (go) begin
                mult_out <= MULT_BITS'(matrix_val) * MULT_BITS'(vec_val);
                p_row    <= row_id_out;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [ACC_W-1:0] acc;
    logic [ROW_W-1:0] cur_row;
    logic             acc_valid;
    logic [CNT_W-1:0] idle_cnt;
    logic [ACC_W-1:0] prod_next;  // product as a fresh row sum
    logic [ACC_W-1:0] sum_next;   // product added to the running sum

`ifdef CHAN_ACC_SATURATE_EN
    // One spare bit above the wider operand catches any carry out of ACC_W.
    localparam int SUM_W = ((ACC_W > MULT_BITS) ? ACC_W : MULT_BITS) + 1;

    logic [SUM_W-1:0] prod_ext;
    logic [SUM_W-1:0] sum_ext;

    always_comb begin
        prod_ext  = SUM_W'(mult_out);
        sum_ext   = SUM_W'(acc) + prod_ext;
        prod_next = (|prod_ext[SUM_W-1:ACC_W]) ? '1 : prod_ext[ACC_W-1:0];
        sum_next  = (|sum_ext[SUM_W-1:ACC_W])  ? '1 : sum_ext[ACC_W-1:0];
    end
`else
    always_comb begin
        prod_next = ACC_W'(mult_out);
        sum_next  = acc + prod_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cur_row   <= '0;
            acc_valid <= 1'b0;
            idle_cnt  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_en <= 1'b0;
            if (mult_rd_en) begin
                idle_cnt <= '0;
                if (!acc_valid) begin
                    acc       <= prod_next;
                    cur_row   <= p_row;
                    acc_valid <= 1'b1;
                end else if (p_row == cur_row) begin
                    acc <= sum_next;
                end else begin
                    // Row boundary: retire the finished row, start the new one.
                    wr_en   <= 1'b1;
                    wr_addr <= cur_row;
                    wr_data <= acc;
                    acc     <= prod_next;
                    cur_row <= p_row;
                end
            end else begin
                // Counter parks at FLUSH_MAX so a long idle stretch cannot
                // wrap it round into a second flush.
                if (idle_cnt != FLUSH_MAX) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
                if (acc_valid && idle_cnt == FLUSH_LAST) begin
                    wr_en     <= 1'b1;
                    wr_addr   <= cur_row;
                    wr_data   <= acc;
                    acc_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_channel_accumulator.sv
`timescale 1ns/1ps
module tb_channel_accumulator;
  import channel_accumulator_pkg::*;

  localparam int DW = 8;
  localparam int RW = 8;
  localparam int MB = mult_bits;
  localparam int AW = 16;
  localparam int FL = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic fifo_rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- signals
  logic          m_wr, v_wr, r_wr;
  logic [DW-1:0] m_din, v_din;
  logic [RW-1:0] r_din;
  logic          m_full, v_full, r_full;
  logic [4:0]    m_cnt, v_cnt, r_cnt;

  logic [DW-1:0] matrix_val, vec_val;
  logic [RW-1:0] row_id_out;
  logic          matrix_val_empty, vec_val_empty, row_id_empty;
  logic          matrix_val_rd_en, vec_val_rd_en, row_id_rd_en;
  logic [MB-1:0] mult_out;
  logic          mult_rd_en;
  logic [AW-1:0] wr_data;
  logic [RW-1:0] wr_addr;
  logic          wr_en;

  logic          tf_wr, tf_rd, tf_full, tf_empty;
  logic [DW-1:0] tf_din, tf_dout;
  logic [4:0]    tf_cnt;

  fifo #(.WIDTH(DW), .DEPTH(16)) m_fifo (
    .clk(clk), .rst(fifo_rst), .wr_en(m_wr), .din(m_din), .full(m_full),
    .rd_en(matrix_val_rd_en), .dout(matrix_val), .empty(matrix_val_empty), .count(m_cnt));
  fifo #(.WIDTH(DW), .DEPTH(16)) v_fifo (
    .clk(clk), .rst(fifo_rst), .wr_en(v_wr), .din(v_din), .full(v_full),
    .rd_en(vec_val_rd_en), .dout(vec_val), .empty(vec_val_empty), .count(v_cnt));
  fifo #(.WIDTH(RW), .DEPTH(16)) r_fifo (
    .clk(clk), .rst(fifo_rst), .wr_en(r_wr), .din(r_din), .full(r_full),
    .rd_en(row_id_rd_en), .dout(row_id_out), .empty(row_id_empty), .count(r_cnt));
  fifo #(.WIDTH(DW), .DEPTH(16)) t_fifo (
    .clk(clk), .rst(fifo_rst), .wr_en(tf_wr), .din(tf_din), .full(tf_full),
    .rd_en(tf_rd), .dout(tf_dout), .empty(tf_empty), .count(tf_cnt));

  channel_accumulator #(
    .DATA_W(DW), .ROW_W(RW), .MULT_BITS(MB), .ACC_W(AW), .FLUSH_CYCLES(FL)
  ) dut (
    .clk(clk), .rst(rst),
    .matrix_val(matrix_val), .matrix_val_empty(matrix_val_empty), .matrix_val_rd_en(matrix_val_rd_en),
    .vec_val(vec_val), .vec_val_empty(vec_val_empty), .vec_val_rd_en(vec_val_rd_en),
    .row_id_out(row_id_out), .row_id_empty(row_id_empty), .row_id_rd_en(row_id_rd_en),
    .mult_out(mult_out), .mult_rd_en(mult_rd_en),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en));

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int row;
    int m;
    int v;
    bit rst_mark;
  } stim_t;

  stim_t             stim_q[$];
  logic [MB-1:0]     exp_mult_q[$];
  logic [RW+AW-1:0]  exp_wr_q[$];
  logic [MB-1:0]     obs_mult_q[$];
  logic [RW+AW-1:0]  obs_wr_q[$];
  int                obs_wr_cyc_q[$];
  int                last_pop = 0;
  int                rd_split = 0;
  int                n_tests  = 0;
  int                n_fail   = 0;

  // Observation happens on the falling edge, between active edges.
  always @(negedge clk) begin
    if (mult_rd_en === 1'b1) obs_mult_q.push_back(mult_out);
    if (wr_en === 1'b1) begin
      obs_wr_q.push_back({wr_addr, wr_data});
      obs_wr_cyc_q.push_back(cyc);
    end
    if (matrix_val_rd_en === 1'b1) last_pop = cyc + 1;
    if (!(matrix_val_rd_en === vec_val_rd_en && vec_val_rd_en === row_id_rd_en)) rd_split++;
  end

  // Row sum arithmetic straight from the rules: wrap or clamp at 2^AW.
  function automatic int acc_add(input int a, input int b);
    int lim;
    int s;
    lim = 1 << AW;
    s   = a + b;
`ifdef CHAN_ACC_SATURATE_EN
    return (s >= lim) ? lim - 1 : s;
`else
    return s % lim;
`endif
  endfunction

  // Reference: every transfer yields one product; consecutive equal rows form
  // one group whose sum is written once; a reset drops the open group; the
  // last open group is written by the idle flush.
  function automatic void build_expected();
    int cur;
    int sum;
    int p;
    bit have;
    cur = 0; sum = 0; have = 0;
    exp_mult_q.delete();
    exp_wr_q.delete();
    foreach (stim_q[i]) begin
      if (stim_q[i].rst_mark) begin
        have = 0;
      end else begin
        p = stim_q[i].m * stim_q[i].v;
        exp_mult_q.push_back(MB'(p));
        if (have && stim_q[i].row == cur) begin
          sum = acc_add(sum, p);
        end else begin
          if (have) exp_wr_q.push_back({RW'(cur), AW'(sum)});
          cur  = stim_q[i].row;
          sum  = acc_add(0, p);
          have = 1;
        end
      end
    end
    if (have) exp_wr_q.push_back({RW'(cur), AW'(sum)});
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit me, input bit ve, input bit re, input int m, input int v, input int r);
    m_wr = me; v_wr = ve; r_wr = re;
    m_din = DW'(m); v_din = DW'(v); r_din = RW'(r);
    tick();
    m_wr = 1'b0; v_wr = 1'b0; r_wr = 1'b0;
  endtask

  task automatic push_triple(input int r, input int m, input int v);
    stim_q.push_back('{r, m, v, 1'b0});
    push(1'b1, 1'b1, 1'b1, m, v, r);
  endtask

  task automatic start_test();
    stim_q.delete();
    obs_mult_q.delete();
    obs_wr_q.delete();
    obs_wr_cyc_q.delete();
  endtask

  task automatic wait_drain();
    int budget;
    budget = 300;
    build_expected();
    while (obs_wr_q.size() < exp_wr_q.size() && budget > 0) begin
      tick();
      budget--;
    end
    repeat (FL + 6) tick();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    start_test();
    rst = 1'b1; fifo_rst = 1'b1;
    repeat (2) tick();
    fifo_rst = 1'b0;
    push_triple(9, 3, 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({matrix_val_rd_en, vec_val_rd_en, row_id_rd_en, mult_rd_en, wr_en, mult_out, wr_addr, wr_data} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: rd_en=%b%b%b mult_rd_en=%b wr_en=%b mult_out=%0h wr_addr=%0h wr_data=%0h, expected all 0",
                 i, matrix_val_rd_en, vec_val_rd_en, row_id_rd_en, mult_rd_en, wr_en, mult_out, wr_addr, wr_data);
      end
    end
    n_tests++;
    if (matrix_val_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fifo_held: matrix_val_empty=%b expected 0", matrix_val_empty);
    end
    rst = 1'b0;
    wait_drain();
    n_tests++;
    if (obs_mult_q.size() != exp_mult_q.size() || obs_wr_q.size() != exp_wr_q.size()) begin
      n_fail++;
      $display("FAIL reset_release_counts: mult %0d/%0d writes %0d/%0d (got/expected)",
               obs_mult_q.size(), exp_mult_q.size(), obs_wr_q.size(), exp_wr_q.size());
    end else begin
      n_tests++;
      if (obs_mult_q[0] !== exp_mult_q[0] || obs_wr_q[0] !== exp_wr_q[0]) begin
        n_fail++;
        $display("FAIL reset_release_data: mult %0h wr %0h, expected mult %0h wr %0h",
                 obs_mult_q[0], obs_wr_q[0], exp_mult_q[0], exp_wr_q[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_test();
    for (int i = 1; i <= 6; i++) push_triple(1, 1, i);
    for (int i = 1; i <= 3; i++) push_triple(2, 1, i);
    wait_drain();
    n_tests++;
    if (obs_mult_q.size() != exp_mult_q.size()) begin
      n_fail++;
      $display("FAIL b2b_mult_count: got %0d expected %0d", obs_mult_q.size(), exp_mult_q.size());
    end
    foreach (exp_mult_q[i]) if (i < obs_mult_q.size()) begin
      n_tests++;
      if (obs_mult_q[i] !== exp_mult_q[i]) begin
        n_fail++;
        $display("FAIL b2b_mult[%0d]: got %0h expected %0h", i, obs_mult_q[i], exp_mult_q[i]);
      end
    end
    n_tests++;
    if (obs_wr_q.size() != exp_wr_q.size()) begin
      n_fail++;
      $display("FAIL b2b_wr_count: got %0d expected %0d", obs_wr_q.size(), exp_wr_q.size());
    end
    foreach (exp_wr_q[i]) if (i < obs_wr_q.size()) begin
      n_tests++;
      if (obs_wr_q[i] !== exp_wr_q[i]) begin
        n_fail++;
        $display("FAIL b2b_wr[%0d]: got addr %0d data %0d expected addr %0d data %0d",
                 i, obs_wr_q[i][RW+AW-1:AW], obs_wr_q[i][AW-1:0], exp_wr_q[i][RW+AW-1:AW], exp_wr_q[i][AW-1:0]);
      end
    end
    if (obs_wr_cyc_q.size() > 0) begin
      n_tests++;
      if (obs_wr_cyc_q[$] - last_pop != FL + 1) begin
        n_fail++;
        $display("FAIL b2b_flush_latency: got %0d edges after last pop expected %0d",
                 obs_wr_cyc_q[$] - last_pop, FL + 1);
      end
    end
  endtask

  task automatic test_empty_gap();
    start_test();
    push_triple(7, 2, 3);
    push_triple(7, 4, 5);
    stim_q.push_back('{7, 6, 2, 1'b0});
    stim_q.push_back('{7, 7, 3, 1'b0});
    push(1'b1, 1'b0, 1'b1, 6, 0, 7);
    push(1'b1, 1'b0, 1'b1, 7, 0, 7);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (vec_val_empty !== 1'b1 || matrix_val_rd_en !== 1'b0 || vec_val_rd_en !== 1'b0 || row_id_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_no_pop[%0d]: vec_empty=%b rd_en=%b%b%b expected 1 and 000",
                 i, vec_val_empty, matrix_val_rd_en, vec_val_rd_en, row_id_rd_en);
      end
      if (i == 0) tick();
    end
    push(1'b0, 1'b1, 1'b0, 0, 2, 0);
    push(1'b0, 1'b1, 1'b0, 0, 3, 0);
    wait_drain();
    n_tests++;
    if (obs_wr_q.size() != exp_wr_q.size() || obs_mult_q.size() != exp_mult_q.size()) begin
      n_fail++;
      $display("FAIL gap_counts: writes %0d/%0d mult %0d/%0d (got/expected)",
               obs_wr_q.size(), exp_wr_q.size(), obs_mult_q.size(), exp_mult_q.size());
    end else begin
      n_tests++;
      if (obs_wr_q[0] !== exp_wr_q[0]) begin
        n_fail++;
        $display("FAIL gap_sum: got %0h expected %0h", obs_wr_q[0], exp_wr_q[0]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] ovf_exp;
`ifdef CHAN_ACC_SATURATE_EN
    ovf_exp = 16'hFFFF;
`else
    ovf_exp = 16'hFC02;
`endif
    start_test();
    push_triple(8, 255, 255);
    push_triple(8, 255, 255);
    wait_drain();
    n_tests++;
    if (obs_wr_q.size() != 1) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d writes expected 1", obs_wr_q.size());
    end else begin
      n_tests++;
      if (obs_wr_q[0] !== {8'd8, ovf_exp} || obs_wr_q[0] !== exp_wr_q[0]) begin
        n_fail++;
        $display("FAIL ovf_sum: got addr %0d data %0h expected addr 8 data %0h",
                 obs_wr_q[0][RW+AW-1:AW], obs_wr_q[0][AW-1:0], ovf_exp);
      end
    end
  endtask

  task automatic test_reset_mid_row();
    start_test();
    push_triple(3, 2, 5);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    stim_q.push_back('{0, 0, 0, 1'b1});
    push_triple(11, 1, 4);
    wait_drain();
    n_tests++;
    if (obs_wr_q.size() != exp_wr_q.size()) begin
      n_fail++;
      $display("FAIL midrst_wr_count: got %0d expected %0d", obs_wr_q.size(), exp_wr_q.size());
    end else begin
      n_tests++;
      if (obs_wr_q[0] !== exp_wr_q[0]) begin
        n_fail++;
        $display("FAIL midrst_wr: got %0h expected %0h", obs_wr_q[0], exp_wr_q[0]);
      end
    end
    n_tests++;
    if (obs_mult_q.size() != exp_mult_q.size()) begin
      n_fail++;
      $display("FAIL midrst_mult_count: got %0d expected %0d", obs_mult_q.size(), exp_mult_q.size());
    end
  endtask

  task automatic test_single_rows();
    start_test();
    push_triple(4, 1, 2);
    push_triple(5, 1, 3);
    push_triple(6, 1, 4);
    wait_drain();
    n_tests++;
    if (obs_wr_q.size() != exp_wr_q.size()) begin
      n_fail++;
      $display("FAIL single_wr_count: got %0d expected %0d", obs_wr_q.size(), exp_wr_q.size());
    end
    foreach (exp_wr_q[i]) if (i < obs_wr_q.size()) begin
      n_tests++;
      if (obs_wr_q[i] !== exp_wr_q[i]) begin
        n_fail++;
        $display("FAIL single_wr[%0d]: got %0h expected %0h", i, obs_wr_q[i], exp_wr_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int row;
    int len;
    start_test();
    rd_split = 0;
    row = int'($urandom_range(0, 255));
    for (int g = 0; g < 12; g++) begin
      len = int'($urandom_range(1, 5));
      row = int'((row + $urandom_range(1, 255)) % 256);
      for (int k = 0; k < len; k++) begin
        push_triple(row, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
      end
    end
    wait_drain();
    n_tests++;
    if (obs_mult_q.size() != exp_mult_q.size() || obs_wr_q.size() != exp_wr_q.size()) begin
      n_fail++;
      $display("FAIL rand_counts: mult %0d/%0d writes %0d/%0d (got/expected)",
               obs_mult_q.size(), exp_mult_q.size(), obs_wr_q.size(), exp_wr_q.size());
    end
    foreach (exp_mult_q[i]) if (i < obs_mult_q.size()) begin
      n_tests++;
      if (obs_mult_q[i] !== exp_mult_q[i]) begin
        n_fail++;
        $display("FAIL rand_mult[%0d]: got %0h expected %0h", i, obs_mult_q[i], exp_mult_q[i]);
      end
    end
    foreach (exp_wr_q[i]) if (i < obs_wr_q.size()) begin
      n_tests++;
      if (obs_wr_q[i] !== exp_wr_q[i]) begin
        n_fail++;
        $display("FAIL rand_wr[%0d]: got %0h expected %0h", i, obs_wr_q[i], exp_wr_q[i]);
      end
    end
    n_tests++;
    if (rd_split != 0) begin
      n_fail++;
      $display("FAIL rand_rd_en_together: got %0d split cycles expected 0", rd_split);
    end
  endtask

  task automatic test_fifo();
    logic [DW-1:0] ref_q[$];
    logic [DW-1:0] val;
    tf_wr = 1'b0; tf_rd = 1'b0;
    for (int i = 0; i < 16; i++) begin
      val = DW'($urandom);
      tf_din = val; tf_wr = 1'b1;
      ref_q.push_back(val);
      tick();
    end
    tf_din = 8'hA5;
    tick();
    tf_wr = 1'b0;
    n_tests++;
    if (tf_full !== 1'b1 || tf_cnt !== 5'd16) begin
      n_fail++;
      $display("FAIL fifo_full: full=%b count=%0d expected 1 and 16", tf_full, tf_cnt);
    end
    val = DW'($urandom);
    n_tests++;
    if (tf_dout !== ref_q[0]) begin
      n_fail++;
      $display("FAIL fifo_head_full: got %0h expected %0h", tf_dout, ref_q[0]);
    end
    tf_din = val; tf_wr = 1'b1; tf_rd = 1'b1;
    tick();
    tf_wr = 1'b0; tf_rd = 1'b0;
    void'(ref_q.pop_front());
    ref_q.push_back(val);
    n_tests++;
    if (tf_full !== 1'b1 || tf_cnt !== 5'd16) begin
      n_fail++;
      $display("FAIL fifo_rw_at_full: full=%b count=%0d expected 1 and 16", tf_full, tf_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (tf_dout !== ref_q[0]) begin
        n_fail++;
        $display("FAIL fifo_order[%0d]: got %0h expected %0h", i, tf_dout, ref_q[0]);
      end
      void'(ref_q.pop_front());
      tf_rd = 1'b1;
      tick();
      tf_rd = 1'b0;
    end
    n_tests++;
    if (tf_empty !== 1'b1 || tf_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL fifo_empty: empty=%b count=%0d expected 1 and 0", tf_empty, tf_cnt);
    end
    tf_din = 8'h3C; tf_wr = 1'b1; tf_rd = 1'b1;
    #1;
    n_tests++;
    if (tf_dout !== 8'h3C) begin
      n_fail++;
      $display("FAIL fifo_passthrough: got %0h expected 3c", tf_dout);
    end
    tick();
    tf_wr = 1'b0;
    tick();
    tf_rd = 1'b0;
    n_tests++;
    if (tf_empty !== 1'b1 || tf_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL fifo_rw_at_empty: empty=%b count=%0d expected 1 and 0", tf_empty, tf_cnt);
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    rst = 1'b1; fifo_rst = 1'b1;
    m_wr = 1'b0; v_wr = 1'b0; r_wr = 1'b0;
    m_din = '0; v_din = '0; r_din = '0;
    tf_wr = 1'b0; tf_rd = 1'b0; tf_din = '0;
    test_reset();
    test_back_to_back();
    test_empty_gap();
    test_overflow();
    test_reset_mid_row();
    test_single_rows();
    test_random();
    test_fifo();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
